// File: rtl/dpram_port_arbiter.sv
// ---------------------------------------------------------------------------
// dpram_port_arbiter
//
// Front-end controller for a 256x8 dual-port RAM shared by two requester
// channels (A and B). Requests are accepted with a valid/ready handshake and
// registered onto the RAM ports. Same-address collisions involving a write
// are serialized with round-robin priority, read data comes back with a
// one-cycle response strobe, and a saturating counter records collisions.
//
// Ports:
//   clk, reset                  clock and asynchronous active-high reset
//   req_valid_X / req_ready_X   request handshake (ready is combinational)
//   req_we_X, req_addr_X,
//   req_wdata_X                 request type, address and write data
//   rsp_valid_X, rsp_rdata_X    one-cycle read response pulse and data
//   ram_we_X, ram_addr_X,
//   ram_wdata_X                 registered command to RAM port X
//   ram_rdata_X                 read data returned by RAM port X
//   collision_cnt               saturating count of collision cycles
// ---------------------------------------------------------------------------
module dpram_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req_valid_A,
  output logic              req_ready_A,
  input  logic              req_we_A,
  input  logic [ADDR_W-1:0] req_addr_A,
  input  logic [DATA_W-1:0] req_wdata_A,
  output logic              rsp_valid_A,
  output logic [DATA_W-1:0] rsp_rdata_A,

  input  logic              req_valid_B,
  output logic              req_ready_B,
  input  logic              req_we_B,
  input  logic [ADDR_W-1:0] req_addr_B,
  input  logic [DATA_W-1:0] req_wdata_B,
  output logic              rsp_valid_B,
  output logic [DATA_W-1:0] rsp_rdata_B,

  output logic              ram_we_A,
  output logic [ADDR_W-1:0] ram_addr_A,
  output logic [DATA_W-1:0] ram_wdata_A,
  input  logic [DATA_W-1:0] ram_rdata_A,

  output logic              ram_we_B,
  output logic [ADDR_W-1:0] ram_addr_B,
  output logic [DATA_W-1:0] ram_wdata_B,
  input  logic [DATA_W-1:0] ram_rdata_B,

  output logic [CNT_W-1:0]  collision_cnt
);

  logic              collision;
  logic              acceptA;
  logic              acceptB;

  logic              prioB_q, prioB_d;
  logic [CNT_W-1:0]  collCnt_q, collCnt_d;

  logic              ramWeA_q, ramWeB_q;
  logic [ADDR_W-1:0] ramAddrA_q, ramAddrB_q;
  logic [DATA_W-1:0] ramWdataA_q, ramWdataB_q;

  logic              rdPendA_q, rdPendB_q;
  logic              rspValidA_q, rspValidB_q;
  logic [DATA_W-1:0] rspRdataA_q, rspRdataB_q;

  // A collision needs both ports valid on the same address with at least one
  // write; two reads of the same address are harmless and both proceed. The
  // pointer names the winner, and after every collision it moves to the
  // loser so a held request is guaranteed to win the repeat collision.
  always_comb begin
    collision   = req_valid_A && req_valid_B &&
                  (req_addr_A == req_addr_B) && (req_we_A || req_we_B);
    req_ready_A = !collision || !prioB_q;
    req_ready_B = !collision ||  prioB_q;
    acceptA     = req_valid_A && req_ready_A;
    acceptB     = req_valid_B && req_ready_B;

    prioB_d   = prioB_q;
    collCnt_d = collCnt_q;
    if (collision) begin
      prioB_d = !prioB_q;
      if (collCnt_q != {CNT_W{1'b1}}) begin
        collCnt_d = collCnt_q + 1'b1;
      end
    end
  end

  // Priority pointer and saturating collision counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prioB_q   <= 1'b0;
      collCnt_q <= '0;
    end else begin
      prioB_q   <= prioB_d;
      collCnt_q <= collCnt_d;
    end
  end

  // Port A issue stage. An accepted request loads the RAM command; otherwise
  // the write enable drops and the last address and data are kept, so each
  // accepted write produces exactly one write-enable cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ramWeA_q    <= 1'b0;
      ramAddrA_q  <= '0;
      ramWdataA_q <= '0;
    end else if (acceptA) begin
      ramWeA_q    <= req_we_A;
      ramAddrA_q  <= req_addr_A;
      ramWdataA_q <= req_wdata_A;
    end else begin
      ramWeA_q    <= 1'b0;
    end
  end

  // Port B issue stage, mirroring port A.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ramWeB_q    <= 1'b0;
      ramAddrB_q  <= '0;
      ramWdataB_q <= '0;
    end else if (acceptB) begin
      ramWeB_q    <= req_we_B;
      ramAddrB_q  <= req_addr_B;
      ramWdataB_q <= req_wdata_B;
    end else begin
      ramWeB_q    <= 1'b0;
    end
  end

  // Read pipeline. The pending flag marks the cycle in which the RAM is
  // returning data for an accepted read; the data is captured on the next
  // edge together with a one-cycle valid pulse. Reset clears the flags, so
  // reads in flight at reset never produce a response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPendA_q   <= 1'b0;
      rdPendB_q   <= 1'b0;
      rspValidA_q <= 1'b0;
      rspValidB_q <= 1'b0;
      rspRdataA_q <= '0;
      rspRdataB_q <= '0;
    end else begin
      rdPendA_q   <= acceptA && !req_we_A;
      rdPendB_q   <= acceptB && !req_we_B;
      rspValidA_q <= rdPendA_q;
      rspValidB_q <= rdPendB_q;
      if (rdPendA_q) begin
        rspRdataA_q <= ram_rdata_A;
      end
      if (rdPendB_q) begin
        rspRdataB_q <= ram_rdata_B;
      end
    end
  end

  assign ram_we_A      = ramWeA_q;
  assign ram_addr_A    = ramAddrA_q;
  assign ram_wdata_A   = ramWdataA_q;
  assign ram_we_B      = ramWeB_q;
  assign ram_addr_B    = ramAddrB_q;
  assign ram_wdata_B   = ramWdataB_q;
  assign rsp_valid_A   = rspValidA_q;
  assign rsp_rdata_A   = rspRdataA_q;
  assign rsp_valid_B   = rspValidB_q;
  assign rsp_rdata_B   = rspRdataB_q;
  assign collision_cnt = collCnt_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dpram_port_arbiter
//
// Testbench for dpram_port_arbiter. A 256x8 memory array attached to the
// RAM ports stands in for the dual-port RAM. Directed scenarios compare
// against hand-computed constants; the random scenario compares against a
// transaction-level model that tracks memory contents, grants and the
// cycle in which every response is due.
// ---------------------------------------------------------------------------
module tb_dpram_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid_A, req_we_A, req_ready_A, rsp_valid_A;
  logic [7:0] req_addr_A, req_wdata_A, rsp_rdata_A;
  logic       req_valid_B, req_we_B, req_ready_B, rsp_valid_B;
  logic [7:0] req_addr_B, req_wdata_B, rsp_rdata_B;
  logic       ram_we_A, ram_we_B;
  logic [7:0] ram_addr_A, ram_wdata_A, ram_rdata_A;
  logic [7:0] ram_addr_B, ram_wdata_B, ram_rdata_B;
  logic [7:0] collision_cnt;

  logic [7:0] mem [256];
  logic       memInit;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [7:0] refMem [256];
  logic       bValA [4];
  logic       bValB [4];
  logic [7:0] bDatA [4];
  logic [7:0] bDatB [4];
  logic       nWeA, nWeB;
  logic [7:0] nAddrA, nAddrB, nWdA, nWdB;
  int         mCnt;
  logic       mPrioB;

  logic       eReadyA, eReadyB, eAccA, eAccB;
  logic       eWeA, eWeB, eRspVA, eRspVB;
  logic [7:0] eAddrA, eAddrB, eWdA, eWdB, eRspDA, eRspDB;
  int         eCnt;

  dpram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid_A(req_valid_A), .req_ready_A(req_ready_A), .req_we_A(req_we_A),
    .req_addr_A(req_addr_A), .req_wdata_A(req_wdata_A),
    .rsp_valid_A(rsp_valid_A), .rsp_rdata_A(rsp_rdata_A),
    .req_valid_B(req_valid_B), .req_ready_B(req_ready_B), .req_we_B(req_we_B),
    .req_addr_B(req_addr_B), .req_wdata_B(req_wdata_B),
    .rsp_valid_B(rsp_valid_B), .rsp_rdata_B(rsp_rdata_B),
    .ram_we_A(ram_we_A), .ram_addr_A(ram_addr_A), .ram_wdata_A(ram_wdata_A),
    .ram_rdata_A(ram_rdata_A),
    .ram_we_B(ram_we_B), .ram_addr_B(ram_addr_B), .ram_wdata_B(ram_wdata_B),
    .ram_rdata_B(ram_rdata_B),
    .collision_cnt(collision_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] initVal(input int i);
    return 8'(i) ^ 8'hA5;
  endfunction

  // Memory stand-in: writes land on the clock edge, read data follows the
  // registered RAM address, so it is ready when the arbiter captures it.
  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 256; i++) mem[i] <= initVal(i);
    end else begin
      if (ram_we_A) mem[ram_addr_A] <= ram_wdata_A;
      if (ram_we_B) mem[ram_addr_B] <= ram_wdata_B;
    end
  end
  assign ram_rdata_A = mem[ram_addr_A];
  assign ram_rdata_B = mem[ram_addr_B];

  // Clear the model's view of everything that reset discards.
  task automatic clearModel();
    for (int i = 0; i < 4; i++) begin
      bValA[i] = 1'b0; bValB[i] = 1'b0; bDatA[i] = 8'h00; bDatB[i] = 8'h00;
    end
    nWeA = 1'b0; nWeB = 1'b0; nAddrA = 8'h00; nAddrB = 8'h00;
    nWdA = 8'h00; nWdB = 8'h00; mCnt = 0; mPrioB = 1'b0;
  endtask

  task automatic setIdle();
    req_valid_A = 1'b0; req_we_A = 1'b0; req_addr_A = 8'h00; req_wdata_A = 8'h00;
    req_valid_B = 1'b0; req_we_B = 1'b0; req_addr_B = 8'h00; req_wdata_B = 8'h00;
  endtask

  task automatic doReset();
    setIdle();
    reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    clearModel();
  endtask

  // Drive one cycle of requests and work out, from the transaction rules,
  // what the outputs must show in this cycle and what the accepted requests
  // will cause later.
  task automatic applyStimulus(input logic vA, input logic weA, input logic [7:0] aA,
                               input logic [7:0] dA, input logic vB, input logic weB,
                               input logic [7:0] aB, input logic [7:0] dB);
    int  slot, due;
    logic col;
    @(posedge clk);
    cyc++;
    #1;
    req_valid_A = vA; req_we_A = weA; req_addr_A = aA; req_wdata_A = dA;
    req_valid_B = vB; req_we_B = weB; req_addr_B = aB; req_wdata_B = dB;
    #3;
    slot = cyc % 4;
    due  = (cyc + 2) % 4;
    eRspVA = bValA[slot]; eRspDA = bDatA[slot]; bValA[slot] = 1'b0;
    eRspVB = bValB[slot]; eRspDB = bDatB[slot]; bValB[slot] = 1'b0;
    eWeA = nWeA; eAddrA = nAddrA; eWdA = nWdA;
    eWeB = nWeB; eAddrB = nAddrB; eWdB = nWdB;
    eCnt = mCnt;
    col = vA && vB && (aA == aB) && (weA || weB);
    eReadyA = !col || !mPrioB;
    eReadyB = !col ||  mPrioB;
    eAccA = vA && eReadyA;
    eAccB = vB && eReadyB;
    if (eAccA && !weA) begin bValA[due] = 1'b1; bDatA[due] = refMem[aA]; end
    if (eAccB && !weB) begin bValB[due] = 1'b1; bDatB[due] = refMem[aB]; end
    if (eAccA && weA) refMem[aA] = dA;
    if (eAccB && weB) refMem[aB] = dB;
    nWeA = eAccA && weA;
    nWeB = eAccB && weB;
    if (eAccA) begin nAddrA = aA; nWdA = dA; end
    if (eAccB) begin nAddrB = aB; nWdB = dB; end
    if (col) begin
      mCnt   = (mCnt >= 255) ? 255 : mCnt + 1;
      mPrioB = eAccA;
    end
  endtask

  // Reset state: every registered output is zero and idle ports are ready.
  task automatic test_reset();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checks++; if ({ram_we_A, ram_we_B, rsp_valid_A, rsp_valid_B} !== 4'b0000) begin
      fails++; $display("[TB] FAIL reset_strobes got %b want 0000",
                        {ram_we_A, ram_we_B, rsp_valid_A, rsp_valid_B}); end
    checks++; if ({ram_addr_A, ram_wdata_A, ram_addr_B, ram_wdata_B, rsp_rdata_A, rsp_rdata_B} !== 48'h0) begin
      fails++; $display("[TB] FAIL reset_data got %h want 0",
                        {ram_addr_A, ram_wdata_A, ram_addr_B, ram_wdata_B, rsp_rdata_A, rsp_rdata_B}); end
    checks++; if (collision_cnt !== 8'd0) begin
      fails++; $display("[TB] FAIL reset_cnt got %0d want 0", collision_cnt); end
    checks++; if ({req_ready_A, req_ready_B} !== 2'b11) begin
      fails++; $display("[TB] FAIL reset_idle_ready got %b want 11", {req_ready_A, req_ready_B}); end
  endtask

  // Writes to different addresses proceed together, then reads return them.
  task automatic test_parallel_writes();
    applyStimulus(1, 1, 8'h00, 8'h0F, 1, 1, 8'h01, 8'h0A);
    checks++; if ({req_ready_A, req_ready_B} !== 2'b11) begin
      fails++; $display("[TB] FAIL par_ready got %b want 11", {req_ready_A, req_ready_B}); end
    applyStimulus(1, 0, 8'h00, 8'h00, 1, 0, 8'h01, 8'h00);
    checks++; if ({ram_we_A, ram_addr_A, ram_wdata_A, ram_we_B, ram_addr_B, ram_wdata_B} !== {1'b1, 8'h00, 8'h0F, 1'b1, 8'h01, 8'h0A}) begin
      fails++; $display("[TB] FAIL par_ramcmd got %b/%h/%h %b/%h/%h want 1/00/0f 1/01/0a",
                        ram_we_A, ram_addr_A, ram_wdata_A, ram_we_B, ram_addr_B, ram_wdata_B); end
    checks++; if (collision_cnt !== 8'd0) begin
      fails++; $display("[TB] FAIL par_cnt got %0d want 0", collision_cnt); end
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checks++; if ({ram_we_A, ram_we_B, rsp_valid_A, rsp_valid_B} !== 4'b0000) begin
      fails++; $display("[TB] FAIL par_gap got %b want 0000",
                        {ram_we_A, ram_we_B, rsp_valid_A, rsp_valid_B}); end
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checks++; if ({rsp_valid_A, rsp_rdata_A, rsp_valid_B, rsp_rdata_B} !== {1'b1, 8'h0F, 1'b1, 8'h0A}) begin
      fails++; $display("[TB] FAIL par_rsp got %b/%h %b/%h want 1/0f 1/0a",
                        rsp_valid_A, rsp_rdata_A, rsp_valid_B, rsp_rdata_B); end
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checks++; if ({rsp_valid_A, rsp_valid_B} !== 2'b00) begin
      fails++; $display("[TB] FAIL par_rsp_pulse got %b want 00", {rsp_valid_A, rsp_valid_B}); end
  endtask

  // Write-write collision with the pointer on A: A first, B one cycle later.
  task automatic test_write_collision();
    applyStimulus(1, 1, 8'h02, 8'h55, 1, 1, 8'h02, 8'hBB);
    checks++; if ({req_ready_A, req_ready_B} !== 2'b10) begin
      fails++; $display("[TB] FAIL wcol_ready got %b want 10", {req_ready_A, req_ready_B}); end
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h02, 8'hBB);
    checks++; if ({req_ready_B, ram_we_A, ram_wdata_A, ram_we_B} !== {1'b1, 1'b1, 8'h55, 1'b0}) begin
      fails++; $display("[TB] FAIL wcol_first got rdyB=%b weA=%b wdA=%h weB=%b want 1 1 55 0",
                        req_ready_B, ram_we_A, ram_wdata_A, ram_we_B); end
    checks++; if (collision_cnt !== 8'd1) begin
      fails++; $display("[TB] FAIL wcol_cnt got %0d want 1", collision_cnt); end
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checks++; if ({ram_we_A, ram_we_B, ram_addr_B, ram_wdata_B} !== {1'b0, 1'b1, 8'h02, 8'hBB}) begin
      fails++; $display("[TB] FAIL wcol_second got weA=%b weB=%b aB=%h wdB=%h want 0 1 02 bb",
                        ram_we_A, ram_we_B, ram_addr_B, ram_wdata_B); end
    applyStimulus(1, 0, 8'h02, 8'h00, 0, 0, 8'h00, 8'h00);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checks++; if ({rsp_valid_A, rsp_rdata_A} !== {1'b1, 8'hBB}) begin
      fails++; $display("[TB] FAIL wcol_readback got %b/%h want 1/bb", rsp_valid_A, rsp_rdata_A); end
  endtask

  // Write/read collision with the pointer on B: B reads the old value first.
  task automatic test_write_read_collision();
    applyStimulus(1, 1, 8'h05, 8'h33, 1, 0, 8'h05, 8'h00);
    checks++; if ({req_ready_A, req_ready_B} !== 2'b01) begin
      fails++; $display("[TB] FAIL wrcol_ready got %b want 01", {req_ready_A, req_ready_B}); end
    applyStimulus(1, 1, 8'h05, 8'h33, 0, 0, 8'h00, 8'h00);
    checks++; if ({req_ready_A, collision_cnt} !== {1'b1, 8'd2}) begin
      fails++; $display("[TB] FAIL wrcol_hold got rdyA=%b cnt=%0d want 1 2", req_ready_A, collision_cnt); end
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checks++; if ({rsp_valid_B, rsp_rdata_B, ram_we_A} !== {1'b1, 8'hA0, 1'b1}) begin
      fails++; $display("[TB] FAIL wrcol_old got %b/%h weA=%b want 1/a0 1",
                        rsp_valid_B, rsp_rdata_B, ram_we_A); end
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'h05, 8'h00);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checks++; if ({rsp_valid_B, rsp_rdata_B} !== {1'b1, 8'h33}) begin
      fails++; $display("[TB] FAIL wrcol_new got %b/%h want 1/33", rsp_valid_B, rsp_rdata_B); end
  endtask

  // Two reads of the same address are not a collision.
  task automatic test_read_read();
    applyStimulus(1, 0, 8'h03, 8'h00, 1, 0, 8'h03, 8'h00);
    checks++; if ({req_ready_A, req_ready_B} !== 2'b11) begin
      fails++; $display("[TB] FAIL rr_ready got %b want 11", {req_ready_A, req_ready_B}); end
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checks++; if ({rsp_valid_A, rsp_rdata_A, rsp_valid_B, rsp_rdata_B, collision_cnt} !== {1'b1, 8'hA6, 1'b1, 8'hA6, 8'd2}) begin
      fails++; $display("[TB] FAIL rr_rsp got %b/%h %b/%h cnt=%0d want 1/a6 1/a6 2",
                        rsp_valid_A, rsp_rdata_A, rsp_valid_B, rsp_rdata_B, collision_cnt); end
  endtask

  // Random traffic on a small address window so collisions are frequent;
  // a stalled requester keeps its request unchanged until accepted.
  task automatic test_random();
    logic       vA = 1'b0, weA = 1'b0, vB = 1'b0, weB = 1'b0;
    logic [7:0] aA = 8'h00, dA = 8'h00, aB = 8'h00, dB = 8'h00;
    doReset();
    for (int n = 0; n < 400; n++) begin
      if (!vA || eAccA) begin
        vA = ($urandom_range(0, 9) < 7); weA = 1'($urandom_range(0, 1));
        aA = 8'($urandom_range(0, 7)); dA = 8'($urandom);
      end
      if (!vB || eAccB) begin
        vB = ($urandom_range(0, 9) < 7); weB = 1'($urandom_range(0, 1));
        aB = 8'($urandom_range(0, 7)); dB = 8'($urandom);
      end
      eAccA = 1'b0; eAccB = 1'b0;
      applyStimulus(vA, weA, aA, dA, vB, weB, aB, dB);
      checks++; if ({req_ready_A, req_ready_B} !== {eReadyA, eReadyB}) begin
        fails++; $display("[TB] FAIL rnd_ready cyc %0d got %b want %b", cyc,
                          {req_ready_A, req_ready_B}, {eReadyA, eReadyB}); end
      checks++; if ({ram_we_A, ram_addr_A, ram_wdata_A} !== {eWeA, eAddrA, eWdA}) begin
        fails++; $display("[TB] FAIL rnd_ramA cyc %0d got %b/%h/%h want %b/%h/%h", cyc,
                          ram_we_A, ram_addr_A, ram_wdata_A, eWeA, eAddrA, eWdA); end
      checks++; if ({ram_we_B, ram_addr_B, ram_wdata_B} !== {eWeB, eAddrB, eWdB}) begin
        fails++; $display("[TB] FAIL rnd_ramB cyc %0d got %b/%h/%h want %b/%h/%h", cyc,
                          ram_we_B, ram_addr_B, ram_wdata_B, eWeB, eAddrB, eWdB); end
      checks++; if (rsp_valid_A !== eRspVA || (eRspVA && rsp_rdata_A !== eRspDA)) begin
        fails++; $display("[TB] FAIL rnd_rspA cyc %0d got %b/%h want %b/%h", cyc,
                          rsp_valid_A, rsp_rdata_A, eRspVA, eRspDA); end
      checks++; if (rsp_valid_B !== eRspVB || (eRspVB && rsp_rdata_B !== eRspDB)) begin
        fails++; $display("[TB] FAIL rnd_rspB cyc %0d got %b/%h want %b/%h", cyc,
                          rsp_valid_B, rsp_rdata_B, eRspVB, eRspDB); end
      checks++; if (int'(collision_cnt) != eCnt) begin
        fails++; $display("[TB] FAIL rnd_cnt cyc %0d got %0d want %0d", cyc, collision_cnt, eCnt); end
    end
  endtask

  // Reset while a read is pending: outputs clear at once, no late response.
  task automatic test_reset_inflight();
    applyStimulus(1, 0, 8'h04, 8'h00, 0, 0, 8'h00, 8'h00);
    @(posedge clk);
    cyc++;
    #1 setIdle();
    #1 reset = 1'b1;
    #1;
    checks++; if ({ram_we_A, ram_addr_A, rsp_valid_A, rsp_valid_B, collision_cnt} !== {1'b0, 8'h00, 1'b0, 1'b0, 8'd0}) begin
      fails++; $display("[TB] FAIL rst_async got weA=%b aA=%h rv=%b%b cnt=%0d want 0 00 00 0",
                        ram_we_A, ram_addr_A, rsp_valid_A, rsp_valid_B, collision_cnt); end
    @(posedge clk);
    #2 reset = 1'b0;
    clearModel();
    for (int n = 0; n < 4; n++) begin
      applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
      checks++; if ({rsp_valid_A, rsp_valid_B} !== 2'b00) begin
        fails++; $display("[TB] FAIL rst_no_rsp step %0d got %b want 00", n, {rsp_valid_A, rsp_valid_B}); end
    end
  endtask

  // Continuous collisions drive the counter to its ceiling and hold it there.
  task automatic test_saturation();
    doReset();
    for (int n = 1; n <= 301; n++) begin
      applyStimulus(1, 1, 8'h10, 8'(n), 1, 1, 8'h10, 8'(n + 1));
      if (n == 255) begin
        checks++; if (collision_cnt !== 8'd254) begin
          fails++; $display("[TB] FAIL sat_before got %0d want 254", collision_cnt); end
      end
      if (n == 256) begin
        checks++; if (collision_cnt !== 8'd255) begin
          fails++; $display("[TB] FAIL sat_reach got %0d want 255", collision_cnt); end
      end
    end
    checks++; if (collision_cnt !== 8'd255) begin
      fails++; $display("[TB] FAIL sat_hold got %0d want 255", collision_cnt); end
  endtask

  // Sequence the scenarios and report.
  initial begin
    setIdle();
    reset   = 1'b1;
    memInit = 1'b1;
    for (int i = 0; i < 256; i++) refMem[i] = initVal(i);
    clearModel();
    eAccA = 1'b0; eAccB = 1'b0;
    @(posedge clk);
    #1 memInit = 1'b0;
    #1 reset = 1'b0;
    $display("[TB] starting");
    test_reset();
    test_parallel_writes();
    test_write_collision();
    test_write_read_collision();
    test_read_read();
    test_random();
    test_reset_inflight();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
